// File: rtl/data_memory_port.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_port
// Brief    : Big-endian byte/half/word load-store port onto a 32-bit word
//            memory; misaligned accesses split across two consecutive words.
// Revision : 1.0
// ============================================================================
module data_memory_port #(
    parameter int MEMORY_DEPTH = 32768
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_store,
    input  logic [1:0]                      req_size,
    input  logic                            req_sign_ext,
    input  logic [31:0]                     req_address,
    input  logic [31:0]                     req_write_data,
    output logic                            resp_valid,
    output logic [31:0]                     resp_data,
    output logic [$clog2(MEMORY_DEPTH)-1:0] mem_address,
    output logic [3:0]                      mem_wen,
    output logic [31:0]                     mem_write_data,
    input  logic [31:0]                     mem_read_data
);

    localparam int AW = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic          r_store, r_sign, r_split;
    logic [2:0]    r_bytes;
    logic [1:0]    r_offset;
    logic [AW-1:0] r_index;
    logic [3:0]    r_wen_lo;
    logic [31:0]   r_wdata_lo, r_first_word;

    logic [2:0]    w_req_bytes;
    logic [1:0]    w_req_offset;
    logic          w_req_split;
    logic [AW-1:0] w_req_index, w_index_next;
    logic [7:0]    w_req_mask;
    logic [31:0]   w_req_lj;
    logic [63:0]   w_req_win;
    logic [31:0]   w_hi_word, w_raw;
    logic [63:0]   w_load_cat;
    logic [31:0]   w_load_result;
    logic          w_unused_addr_bits;

    assign w_unused_addr_bits = &{1'b0, req_address[31:AW+2]};

    assign w_req_bytes  = (req_size == 2'b00) ? 3'd1 : (req_size == 2'b01) ? 3'd2 : 3'd4;
    assign w_req_offset = req_address[1:0];
    assign w_req_split  = ({1'b0, w_req_offset} + w_req_bytes) > 3'd4;
    assign w_req_index  = req_address[AW+1:2];

    // Both words of a potentially split access are built as one 64-bit
    // big-endian window: upper half is the first word, lower half the second.
    assign w_req_mask = ((w_req_bytes == 3'd1) ? 8'b1000_0000 :
                         (w_req_bytes == 3'd2) ? 8'b1100_0000 : 8'b1111_0000) >> w_req_offset;
    assign w_req_lj   = req_write_data << {3'd4 - w_req_bytes, 3'b000};
    assign w_req_win  = {w_req_lj, 32'h0} >> {w_req_offset, 3'b000};

    assign w_index_next = (r_index == AW'(MEMORY_DEPTH - 1)) ? '0 : r_index + AW'(1);

    assign w_hi_word  = r_split ? r_first_word : mem_read_data;
    assign w_load_cat = {w_hi_word, mem_read_data} << {r_offset, 3'b000};
    assign w_raw      = w_load_cat[63:32] >> {3'd4 - r_bytes, 3'b000};

    always_comb begin
        w_load_result = w_raw;
        if (r_store) begin
            w_load_result = 32'h0;
        end else if (r_sign && r_bytes == 3'd1) begin
            w_load_result = {{24{w_raw[7]}}, w_raw[7:0]};
        end else if (r_sign && r_bytes == 3'd2) begin
            w_load_result = {{16{w_raw[15]}}, w_raw[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        mem_address    = r_index;
        mem_wen        = 4'b0000;
        mem_write_data = 32'h0;
        case (r_state)
            IDLE: begin
                req_ready      = 1'b1;
                mem_address    = w_req_index;
                mem_write_data = w_req_win[63:32];
                if (req_valid) begin
                    if (req_store) begin
                        mem_wen = w_req_mask[7:4];
                    end
                    w_next = w_req_split ? SECOND : FINISH;
                end
            end
            SECOND: begin
                mem_address    = w_index_next;
                mem_write_data = r_wdata_lo;
                if (r_store) begin
                    mem_wen = r_wen_lo;
                end
                w_next = FINISH;
            end
            FINISH: begin
                mem_address = r_split ? w_index_next : r_index;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        // Reset must silence the port even though the state is already IDLE.
        if (!rst_n) begin
            req_ready = 1'b0;
            mem_wen   = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store      <= 1'b0;
            r_sign       <= 1'b0;
            r_split      <= 1'b0;
            r_bytes      <= 3'd4;
            r_offset     <= 2'b00;
            r_index      <= '0;
            r_wen_lo     <= 4'b0000;
            r_wdata_lo   <= 32'h0;
            r_first_word <= 32'h0;
            resp_valid   <= 1'b0;
            resp_data    <= 32'h0;
        end else begin
            resp_valid <= (r_state == FINISH);
            if (r_state == IDLE && req_valid) begin
                r_store    <= req_store;
                r_sign     <= req_sign_ext;
                r_split    <= w_req_split;
                r_bytes    <= w_req_bytes;
                r_offset   <= w_req_offset;
                r_index    <= w_req_index;
                r_wen_lo   <= w_req_mask[3:0];
                r_wdata_lo <= w_req_win[31:0];
            end
            if (r_state == SECOND) begin
                r_first_word <= mem_read_data;
            end
            if (r_state == FINISH) begin
                resp_data <= w_load_result;
            end
        end
    end

endmodule
`default_nettype wire
